// File: rtl/rx_bit_frontend.sv
// rx_bit_frontend
// Serial HDLC receive front end. Samples one line bit per enabled clock
// edge, detects flags (8'h7E), aborts (seven consecutive 1s) and stuffed
// zeros, and reassembles destuffed data bytes LSB first.
//
// Received bits pass through an 8-bit window (det) before being treated as
// data. This delay is what lets a closing flag retract its own leading bits:
// when the flag completes, every bit still in the window belongs to the flag
// and is dropped by clearing the per-bit valid mask (vld).
//
// Ports
//   Clk            : clock, all state updates on the rising edge
//   Rst            : synchronous active-high reset, overrides RxEN
//   Rx             : serial line bit, LSB of each byte first
//   RxEN           : bit enable, Rx is sampled only when high
//   Rx_Data        : last assembled destuffed byte, first received bit at bit 0
//   Rx_NewByte     : one-cycle strobe, Rx_Data just updated
//   Rx_FlagDetect  : one-cycle strobe, flag received
//   Rx_AbortDetect : one-cycle strobe, seventh consecutive 1 received
//   ZeroDetect     : one-cycle strobe, stuffed zero removed
//   Rx_EoF         : one-cycle strobe, byte-aligned frame closed by a flag
//   Rx_FrameError  : one-cycle strobe, closing flag not byte-aligned
//   Rx_ValidFrame  : level, receiver is inside a frame (FSM state FRAME)
module rx_bit_frontend (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       ZeroDetect,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_ValidFrame
);

  typedef enum logic {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] det;
  logic [7:0] vld;
  logic [2:0] onesCnt;
  logic [2:0] bitCnt;
  logic       gotByte;
  logic [7:0] shiftReg;

  logic [7:0] detNext;
  logic       isFlag;
  logic       isStuff;
  logic       isAbort;
  logic       inFrame;
  logic       takeBit;
  logic [7:0] byteNext;
  logic       byteDone;
  logic [2:0] bitCntNext;
  logic       gotByteNext;
  logic       vBit;

  // The FSM state is visible directly as the frame-valid level.
  assign Rx_ValidFrame = (state == FRAME);

  always_comb begin
    detNext     = {Rx, det[7:1]};
    isFlag      = (detNext == 8'h7E);
    isStuff     = !Rx && (onesCnt == 3'd5);
    isAbort     = Rx && (onesCnt == 3'd6);
    inFrame     = (state == FRAME);
    // An abort discards the frame, so the bit leaving the window on that
    // same edge is not allowed to complete a byte.
    takeBit     = inFrame && vld[0] && !isAbort;
    byteNext    = {det[0], shiftReg[7:1]};
    byteDone    = takeBit && (bitCnt == 3'd7);
    bitCntNext  = takeBit ? bitCnt + 3'd1 : bitCnt;
    gotByteNext = gotByte || byteDone;
    vBit        = inFrame && !isStuff;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= HUNT;
      det            <= 8'h00;
      vld            <= 8'h00;
      onesCnt        <= 3'd0;
      bitCnt         <= 3'd0;
      gotByte        <= 1'b0;
      shiftReg       <= 8'h00;
      Rx_Data        <= 8'h00;
      Rx_NewByte     <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      ZeroDetect     <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
    end else begin
      Rx_NewByte     <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      ZeroDetect     <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;

      if (RxEN) begin
        det            <= detNext;
        onesCnt        <= Rx ? ((onesCnt == 3'd7) ? 3'd7 : onesCnt + 3'd1) : 3'd0;
        ZeroDetect     <= isStuff;
        Rx_FlagDetect  <= isFlag;
        Rx_AbortDetect <= isAbort;

        if (takeBit) begin
          shiftReg <= byteNext;
        end
        if (byteDone) begin
          Rx_Data    <= byteNext;
          Rx_NewByte <= 1'b1;
        end

        if (isFlag) begin
          // The bit leaving the window was handled above; the closing
          // decision uses the counts after that bit. The same flag opens
          // the next frame, so the state stays (or becomes) FRAME.
          vld     <= 8'h00;
          bitCnt  <= 3'd0;
          gotByte <= 1'b0;
          state   <= FRAME;
          if (inFrame) begin
            Rx_FrameError <= (bitCntNext != 3'd0);
            Rx_EoF        <= (bitCntNext == 3'd0) && gotByteNext;
          end
        end else if (isAbort) begin
          vld     <= 8'h00;
          bitCnt  <= 3'd0;
          gotByte <= 1'b0;
          state   <= HUNT;
        end else begin
          vld     <= {vBit, vld[7:1]};
          bitCnt  <= bitCntNext;
          gotByte <= gotByteNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_bit_frontend.sv
// tb_rx_bit_frontend
// Bench for rx_bit_frontend. A transmit side builds HDLC bit streams (flags,
// stuffed bytes, raw bits) and plays them with optional RxEN gaps. A
// reference model consumes the same enabled bits: it destuffs, keeps data
// bits in a timestamped pending list that is committed eight enabled bits
// later unless a flag or abort retracts it, and packs committed bits into
// bytes. Every DUT output is compared with the model on every cycle.
module tb_rx_bit_frontend;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx = 1'b0;
  logic       RxEN = 1'b0;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       ZeroDetect;
  logic       Rx_EoF;
  logic       Rx_FrameError;
  logic       Rx_ValidFrame;

  rx_bit_frontend dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Rx             (Rx),
    .RxEN           (RxEN),
    .Rx_Data        (Rx_Data),
    .Rx_NewByte     (Rx_NewByte),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_AbortDetect (Rx_AbortDetect),
    .ZeroDetect     (ZeroDetect),
    .Rx_EoF         (Rx_EoF),
    .Rx_FrameError  (Rx_FrameError),
    .Rx_ValidFrame  (Rx_ValidFrame)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // counters and checker
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  typedef struct {
    bit b;
    int stamp;
  } pend_t;

  bit         mInFrame;
  int         mOnes;
  bit         mHist[$];
  pend_t      mPend[$];
  bit         mBits[$];
  bit         mGot;
  int         mEdge;
  logic [7:0] mData;
  bit eNew, eFlag, eAbort, eZero, eEof, eErr;

  task automatic modelReset();
    mInFrame = 1'b0;
    mOnes    = 0;
    mHist.delete();
    for (int i = 0; i < 8; i++) mHist.push_back(1'b0);
    mPend.delete();
    mBits.delete();
    mGot  = 1'b0;
    mEdge = 0;
    mData = 8'h00;
  endtask

  task automatic modelEdge(input bit b);
    bit    flag;
    bit    stuff;
    bit    abort;
    pend_t p;
    mEdge++;
    mHist.push_back(b);
    void'(mHist.pop_front());
    // last eight received bits, oldest first, must read 0 1 1 1 1 1 1 0
    flag = 1'b1;
    for (int i = 0; i < 8; i++)
      if (mHist[i] != ((i == 0 || i == 7) ? 1'b0 : 1'b1)) flag = 1'b0;
    stuff = (b == 1'b0) && (mOnes == 5);
    abort = (b == 1'b1) && (mOnes == 6);
    mOnes = b ? ((mOnes < 7) ? mOnes + 1 : 7) : 0;
    eZero  = stuff;
    eFlag  = flag;
    eAbort = abort;
    if (abort) begin
      mPend.delete();
      mBits.delete();
      mGot     = 1'b0;
      mInFrame = 1'b0;
    end else begin
      if (mPend.size() > 0 && mPend[0].stamp == mEdge - 8) begin
        p = mPend.pop_front();
        mBits.push_back(p.b);
        if (mBits.size() == 8) begin
          for (int i = 0; i < 8; i++) mData[i] = mBits[i];
          eNew = 1'b1;
          mBits.delete();
          mGot = 1'b1;
        end
      end
      if (flag) begin
        if (mInFrame) begin
          if (mBits.size() != 0) eErr = 1'b1;
          else if (mGot)         eEof = 1'b1;
        end
        mPend.delete();
        mBits.delete();
        mGot     = 1'b0;
        mInFrame = 1'b1;
      end else if (mInFrame && !stuff) begin
        p.b     = b;
        p.stamp = mEdge;
        mPend.push_back(p);
      end
    end
  endtask

  // scoreboard for directed byte sequences
  logic [7:0] exp_q[$];
  bit         sbOn = 1'b0;
  int         sbExtra = 0;

  // per-scenario strobe counts
  int cntNew, cntFlag, cntAbort, cntZero, cntEof, cntErr, cntBoth;

  task automatic startScen();
    cntNew = 0; cntFlag = 0; cntAbort = 0; cntZero = 0;
    cntEof = 0; cntErr = 0; cntBoth = 0; sbExtra = 0;
    exp_q.delete();
  endtask

  // driver: one clock with given inputs, then compare against model
  task automatic tick(input logic rx, input logic en, input logic rst);
    Rx = rx; RxEN = en; Rst = rst;
    @(posedge Clk);
    #1;
    eNew = 0; eFlag = 0; eAbort = 0; eZero = 0; eEof = 0; eErr = 0;
    if (rst) modelReset();
    else if (en) modelEdge(rx);
    check("newByte",    8'(Rx_NewByte),     8'(eNew));
    check("flagDetect", 8'(Rx_FlagDetect),  8'(eFlag));
    check("abortDetect",8'(Rx_AbortDetect), 8'(eAbort));
    check("zeroDetect", 8'(ZeroDetect),     8'(eZero));
    check("eof",        8'(Rx_EoF),         8'(eEof));
    check("frameError", 8'(Rx_FrameError),  8'(eErr));
    check("validFrame", 8'(Rx_ValidFrame),  8'(mInFrame));
    check("rxData",     Rx_Data,            mData);
    if (Rx_NewByte) cntNew++;
    if (Rx_FlagDetect) cntFlag++;
    if (Rx_AbortDetect) cntAbort++;
    if (ZeroDetect) cntZero++;
    if (Rx_EoF) cntEof++;
    if (Rx_FrameError) cntErr++;
    if (Rx_NewByte && Rx_EoF) cntBoth++;
    if (sbOn && Rx_NewByte) begin
      if (exp_q.size() > 0) check("sbData", Rx_Data, exp_q.pop_front());
      else sbExtra++;
    end
  endtask

  // transmit side
  bit txq[$];
  int txOnes = 0;

  task automatic qFlag();
    for (int i = 0; i < 8; i++) txq.push_back((i == 0 || i == 7) ? 1'b0 : 1'b1);
    txOnes = 0;
  endtask

  task automatic qBits(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      txq.push_back(d[i]);
      if (d[i]) begin
        txOnes++;
        if (txOnes == 5) begin
          txq.push_back(1'b0);
          txOnes = 0;
        end
      end else begin
        txOnes = 0;
      end
    end
  endtask

  task automatic qByte(input logic [7:0] d);
    qBits({8'h00, d}, 8);
  endtask

  task automatic qRaw(input bit b, input int n);
    for (int i = 0; i < n; i++) txq.push_back(b);
    txOnes = 0;
  endtask

  // gapPct: chance per cycle of an RxEN=0 cycle with a random line value
  task automatic play(input int gapPct);
    while (txq.size() > 0) begin
      if ($urandom_range(99) < gapPct) tick(1'($urandom_range(1)), 1'b0, 1'b0);
      else tick(txq.pop_front(), 1'b1, 1'b0);
    end
  endtask

  initial begin
    modelReset();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // idle ones then a flag opens a frame
    startScen();
    qRaw(1'b1, 16);
    qFlag();
    play(0);
    check("s1FlagCnt", 8'(cntFlag), 8'd1);
    check("s1Valid",   8'(Rx_ValidFrame), 8'd1);
    check("s1NewCnt",  8'(cntNew), 8'd0);

    // two bytes in a byte-aligned frame
    startScen();
    sbOn = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    qFlag(); qByte(8'hA5); qByte(8'h3C); qFlag();
    play(0);
    check("s2NewCnt",  8'(cntNew), 8'd2);
    check("s2EofCnt",  8'(cntEof), 8'd1);
    check("s2EofWithByte", 8'(cntBoth), 8'd1);
    check("s2ErrCnt",  8'(cntErr), 8'd0);
    check("s2SbLeft",  8'(exp_q.size()), 8'd0);
    check("s2SbExtra", 8'(sbExtra), 8'd0);

    // all-ones byte needs one stuffed zero
    startScen();
    exp_q.push_back(8'hFF);
    qFlag(); qByte(8'hFF); qFlag();
    play(0);
    check("s3ZeroCnt", 8'(cntZero), 8'd1);
    check("s3NewCnt",  8'(cntNew), 8'd1);
    check("s3EofCnt",  8'(cntEof), 8'd1);
    check("s3SbLeft",  8'(exp_q.size()), 8'd0);
    sbOn = 1'b0;

    // twelve data bits: one byte then a misaligned close
    startScen();
    qFlag(); qBits(16'h0B6D, 12); qFlag();
    play(0);
    check("s4NewCnt", 8'(cntNew), 8'd1);
    check("s4ErrCnt", 8'(cntErr), 8'd1);
    check("s4EofCnt", 8'(cntEof), 8'd0);

    // abort inside a frame
    startScen();
    qFlag(); qByte(8'h55); qRaw(1'b1, 8);
    play(0);
    check("s5AbortCnt", 8'(cntAbort), 8'd1);
    check("s5Valid",    8'(Rx_ValidFrame), 8'd0);
    check("s5EofCnt",   8'(cntEof), 8'd0);
    check("s5NewCnt",   8'(cntNew), 8'd0);

    // RxEN gaps and a reset in the middle of a byte
    startScen();
    qFlag(); qBits(16'h0005, 4);
    play(40);
    tick(1'b1, 1'b1, 1'b1);
    check("s6ValidAfterRst", 8'(Rx_ValidFrame), 8'd0);
    check("s6DataAfterRst",  Rx_Data, 8'h00);
    startScen();
    qBits(16'h0005, 4); qByte(8'hA5);
    play(40);
    check("s6NoByteBeforeFlag", 8'(cntNew), 8'd0);
    startScen();
    qFlag(); qByte(8'h3C); qFlag();
    play(40);
    check("s6NewCnt", 8'(cntNew), 8'd1);
    check("s6EofCnt", 8'(cntEof), 8'd1);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(3);
      case (kind)
        0: begin
          int nb;
          nb = $urandom_range(4);
          qFlag();
          for (int j = 0; j < nb; j++) qByte(8'($urandom_range(255)));
          qFlag();
        end
        1: begin
          qFlag();
          qBits(16'($urandom_range(65535)), $urandom_range(1, 16));
          qFlag();
        end
        2: begin
          qFlag();
          qByte(8'($urandom_range(255)));
          qRaw(1'b1, $urandom_range(7, 10));
        end
        default: begin
          int n;
          n = $urandom_range(1, 30);
          for (int j = 0; j < n; j++) txq.push_back(1'($urandom_range(1)));
          txOnes = 0;
        end
      endcase
      play($urandom_range(30));
      if ($urandom_range(14) == 0) tick(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
